// File: rtl/dsp_audio_pkg.sv
// Shared audio constants and types used by the S-DSP core and its output blocks.
package dsp_audio_pkg;

  localparam int unsigned CLOCKS_PER_SAMPLE = 64;
  localparam int unsigned DSP_SAMPLE_WIDTH  = 16;

  localparam int unsigned I2S_SLOT_BITS     = 16;
  localparam int unsigned I2S_BCLK_HALF_DIV = 1;
  localparam int unsigned I2S_FRAME_BITS    = 2 * I2S_SLOT_BITS;

  typedef logic signed [DSP_SAMPLE_WIDTH-1:0] sample_t;

  // Word-select polarity on the wire.
  typedef enum logic {
    ChanLeft  = 1'b0,
    ChanRight = 1'b1
  } i2s_chan_e;

endpackage

// File: rtl/dsp_i2s_bclk_gen.sv
// Bit-clock generator: divides the system clock into BCLK and flags the clock on which
// BCLK falls, so the parent can advance its serialiser in lock-step with the pin.
module dsp_i2s_bclk_gen #(
  parameter int unsigned BCLK_HALF_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic bclk_o,
  output logic fall_o
);

  localparam int unsigned DivW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic            term;

  always_comb begin
    term   = (div_q == DivLast);
    div_d  = term ? '0 : div_q + 1'b1;
    bclk_d = term ? ~bclk_q : bclk_q;
  end

  // Asserted on the clock whose edge takes the registered BCLK from 1 to 0.
  assign fall_o = term & bclk_q;
  assign bclk_o = bclk_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/dsp_i2s_tx.sv
// I2S transmitter for the S-DSP mixer output: double-buffers one L/R sample per frame and
// serialises it MSB first with the standard one-bit word-select delay.
module dsp_i2s_tx
  import dsp_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH  = DSP_SAMPLE_WIDTH,
  parameter int unsigned SLOT_BITS     = I2S_SLOT_BITS,
  parameter int unsigned BCLK_HALF_DIV = I2S_BCLK_HALF_DIV
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    overrun,
  output logic [7:0]              underrun_count
);

  localparam int unsigned FrameBits = 2 * SLOT_BITS;
  localparam int unsigned IdxW      = $clog2(FrameBits);
  localparam int unsigned PadBits   = SLOT_BITS - SAMPLE_WIDTH;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FrameBits - 1);
  localparam logic [IdxW-1:0] IdxSlot = IdxW'(SLOT_BITS);

  // Left-justify a sample in its slot; unused LSBs go out as zeros.
  function automatic logic [SLOT_BITS-1:0] pad_slot(input logic [SAMPLE_WIDTH-1:0] s);
    logic [SLOT_BITS-1:0] w;
    w = SLOT_BITS'(s);
    return w << PadBits;
  endfunction

  logic bclk;
  logic fall;

  dsp_i2s_bclk_gen #(
    .BCLK_HALF_DIV(BCLK_HALF_DIV)
  ) u_bclk_gen (
    .clock (clock),
    .reset (reset),
    .bclk_o(bclk),
    .fall_o(fall)
  );

  logic [IdxW-1:0]      b_q, b_d;
  logic [FrameBits-1:0] hold_q, hold_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic [FrameBits-1:0] last_q, last_d;
  logic [FrameBits-1:0] in_frame, load_frame;
  logic                 pend_q, pend_d;
  logic                 sdata_q, sdata_d;
  logic                 fs_q, fs_d;
  logic                 ur_q, ur_d;
  logic                 or_q, or_d;
  logic [7:0]           ucnt_q, ucnt_d;
  i2s_chan_e            lrclk_q, lrclk_d;
  logic                 load;

  assign in_frame = {pad_slot(sample_l), pad_slot(sample_r)};
  // The shifter reloads on the falling event that moves the bit index from 0 to 1.
  assign load     = fall && (b_q == '0);

  always_comb begin
    b_d        = b_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    last_d     = last_q;
    pend_d     = pend_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    ucnt_d     = ucnt_q;
    fs_d       = 1'b0;
    ur_d       = 1'b0;
    or_d       = 1'b0;
    load_frame = last_q;

    if (sample_valid) begin
      hold_d = in_frame;
      pend_d = 1'b1;
      or_d   = pend_q && !load;
    end

    if (fall) begin
      b_d     = (b_q == IdxLast) ? '0 : b_q + 1'b1;
      lrclk_d = (b_d < IdxSlot) ? ChanLeft : ChanRight;
      fs_d    = (b_d == '0);

      if (load) begin
        if (sample_valid) begin
          load_frame = in_frame;
        end else if (pend_q) begin
          load_frame = hold_q;
        end else begin
          // Nothing new arrived: replay the previous frame so the DAC sees a hold, not silence.
          ur_d = 1'b1;
          if (ucnt_q != 8'hFF) begin
            ucnt_d = ucnt_q + 8'd1;
          end
        end
        pend_d  = 1'b0;
        last_d  = load_frame;
        sdata_d = load_frame[FrameBits-1];
        shift_d = {load_frame[FrameBits-2:0], 1'b0};
      end else begin
        sdata_d = shift_q[FrameBits-1];
        shift_d = {shift_q[FrameBits-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      b_q     <= IdxLast;
      hold_q  <= '0;
      shift_q <= '0;
      last_q  <= '0;
      pend_q  <= 1'b0;
      sdata_q <= 1'b0;
      lrclk_q <= ChanRight;
      ucnt_q  <= 8'd0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      or_q    <= 1'b0;
    end else begin
      b_q     <= b_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      sdata_q <= sdata_d;
      lrclk_q <= lrclk_d;
      ucnt_q  <= ucnt_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      or_q    <= or_d;
    end
  end

  assign i2s_bclk       = bclk;
  assign i2s_lrclk      = lrclk_q;
  assign i2s_sdata      = sdata_q;
  assign frame_start    = fs_q;
  assign underrun       = ur_q;
  assign overrun        = or_q;
  assign underrun_count = ucnt_q;

endmodule
